ram_master: RTL and testbench

Initiator for the team's single-port RAM interface (`address`, `data_in`, `data_out`, `clk`, `wr`, `rd`, `cs`). It sits between a client that issues read/write commands over a valid/ready handshake and the RAM instance, and drives every RAM bus signal from registers. Commands are buffered in a small FIFO and executed in order. Read data is returned on a held response channel with backpressure.

---
 rtl/ram_master.sv | 174 +++++++++++++++++
 tb/tb_ram_master.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_master.sv
// Single-port RAM initiator: queues client read/write commands in a small FIFO and
// drives the RAM bus from registers, returning read data on a held response channel.
module ram_master #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 8,
   parameter int RD_LATENCY = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_we,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [DATA_WIDTH-1:0] cmd_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  busy,
   output logic [ADDR_WIDTH-1:0] address,
   output logic [DATA_WIDTH-1:0] data_in,
   output logic                  cs,
   output logic                  wr,
   output logic                  rd,
   input  logic [DATA_WIDTH-1:0] data_out
);

   // state  | meaning
   // IDLE   | bus released, waiting for a queued command
   // ACCESS | cs plus wr or rd asserted for one cycle
   // WAIT   | counting down RAM read latency
   // RESP   | read data held until the client takes it
   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_RESP} state_t;

   localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W   = PTR_W + 1;
   localparam int WAIT_W  = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
   localparam int ENTRY_W = 1 + ADDR_WIDTH + DATA_WIDTH;

   logic [ENTRY_W-1:0]    fifo_mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]      count_q;
   logic                  fifo_full, fifo_empty, push, pop, load_head;
   logic                  head_we;
   logic [ADDR_WIDTH-1:0] head_addr;
   logic [DATA_WIDTH-1:0] head_wdata;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] address_q, address_d;
   logic [DATA_WIDTH-1:0] data_in_q, data_in_d;
   logic                  cs_q, cs_d, wr_q, wr_d, rd_q, rd_d;
   logic                  rsp_valid_q, rsp_valid_d;
   logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
   logic [WAIT_W-1:0]     wait_cnt_q, wait_cnt_d;

   assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
   assign fifo_empty = (count_q == '0);
   // A full FIFO refuses even when a pop is happening in the same cycle.
   assign cmd_ready  = !fifo_full && !rst;
   assign push       = cmd_valid && cmd_ready;
   assign {head_we, head_addr, head_wdata} = fifo_mem_q[rd_ptr_q];

   always_ff @(posedge clk) begin
      if (push) fifo_mem_q[wr_ptr_q] <= {cmd_we, cmd_addr, cmd_wdata};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         address_q   <= '0;
         data_in_q   <= '0;
         cs_q        <= 1'b0;
         wr_q        <= 1'b0;
         rd_q        <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         wait_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         address_q   <= address_d;
         data_in_q   <= data_in_d;
         cs_q        <= cs_d;
         wr_q        <= wr_d;
         rd_q        <= rd_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         wait_cnt_q  <= wait_cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (!fifo_empty) state_d = S_ACCESS;
         S_ACCESS: begin
            if (!wr_q)           state_d = S_WAIT;
            else if (fifo_empty) state_d = S_IDLE;
         end
         S_WAIT:   if (wait_cnt_q == '0) state_d = S_RESP;
         S_RESP:   if (rsp_ready) state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_comb begin
      load_head   = 1'b0;
      pop         = 1'b0;
      address_d   = address_q;
      data_in_d   = data_in_q;
      cs_d        = cs_q;
      wr_d        = wr_q;
      rd_d        = rd_q;
      rsp_valid_d = rsp_valid_q;
      rsp_rdata_d = rsp_rdata_q;
      wait_cnt_d  = wait_cnt_q;
      case (state_q)
         S_IDLE:   load_head = !fifo_empty;
         S_ACCESS: begin
            if (wr_q) begin
               if (!fifo_empty) load_head = 1'b1;
               else {cs_d, wr_d, rd_d} = 3'b000;
            end else begin
               cs_d       = 1'b0;
               rd_d       = 1'b0;
               wait_cnt_d = WAIT_W'(RD_LATENCY - 1);
            end
         end
         S_WAIT: begin
            if (wait_cnt_q == '0) begin
               rsp_rdata_d = data_out;
               rsp_valid_d = 1'b1;
            end else begin
               wait_cnt_d = wait_cnt_q - WAIT_W'(1);
            end
         end
         S_RESP:   if (rsp_ready) rsp_valid_d = 1'b0;
         default:  ;
      endcase
      if (load_head) begin
         pop       = 1'b1;
         address_d = head_addr;
         cs_d      = 1'b1;
         wr_d      = head_we;
         rd_d      = !head_we;
         if (head_we) data_in_d = head_wdata;
      end
   end

   assign address   = address_q;
   assign data_in   = data_in_q;
   assign cs        = cs_q;
   assign wr        = wr_q;
   assign rd        = rd_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign busy      = !fifo_empty || (state_q != S_IDLE);

endmodule

// File: tb/tb_ram_master.sv
// Directed bench for ram_master: one instance at read latency 1, one at latency 3,
// each attached to a behavioural single-port RAM inside this module.
module tb_ram_master;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic       cmd_valid = 0, cmd_we = 0, rsp_ready = 0;
   logic [7:0] cmd_addr = 0, cmd_wdata = 0;
   logic       cmd_ready, rsp_valid, busy, cs, wr, rd;
   logic [7:0] rsp_rdata, address, data_in, data_out;

   logic       l3_cmd_valid = 0, l3_cmd_we = 0, l3_rsp_ready = 1;
   logic [7:0] l3_cmd_addr = 0, l3_cmd_wdata = 0;
   logic       l3_cmd_ready, l3_rsp_valid, l3_busy, l3_cs, l3_wr, l3_rd;
   logic [7:0] l3_rsp_rdata, l3_address, l3_data_in, l3_data_out;

   int total = 0;
   int bad = 0;
   int proto_err = 0;

   ram_master #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .RD_LATENCY(1), .FIFO_DEPTH(4)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_rdata(rsp_rdata), .busy(busy), .address(address), .data_in(data_in), .cs(cs),
      .wr(wr), .rd(rd), .data_out(data_out));

   ram_master #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .RD_LATENCY(3), .FIFO_DEPTH(4)) dut_l3 (
      .clk(clk), .rst(rst), .cmd_valid(l3_cmd_valid), .cmd_ready(l3_cmd_ready),
      .cmd_we(l3_cmd_we), .cmd_addr(l3_cmd_addr), .cmd_wdata(l3_cmd_wdata),
      .rsp_valid(l3_rsp_valid), .rsp_ready(l3_rsp_ready), .rsp_rdata(l3_rsp_rdata),
      .busy(l3_busy), .address(l3_address), .data_in(l3_data_in), .cs(l3_cs), .wr(l3_wr),
      .rd(l3_rd), .data_out(l3_data_out));

   // RAM models: data_out shows the read value only in its valid cycle, zero otherwise.
   logic [7:0] mem1 [256];
   logic [7:0] mem3 [256];
   logic [7:0] pipe1;
   logic [7:0] pipe3 [3];

   initial begin
      for (int i = 0; i < 256; i++) begin
         mem1[i] = 8'h00;
         mem3[i] = 8'h00;
      end
   end

   always @(posedge clk) begin
      if (cs && wr) mem1[address] <= data_in;
      pipe1 <= (cs && rd) ? mem1[address] : 8'h00;
      if (l3_cs && l3_wr) mem3[l3_address] <= l3_data_in;
      pipe3[0] <= (l3_cs && l3_rd) ? mem3[l3_address] : 8'h00;
      pipe3[1] <= pipe3[0];
      pipe3[2] <= pipe3[1];
   end
   assign data_out    = pipe1;
   assign l3_data_out = pipe3[2];

   always @(negedge clk) begin
      if (!rst) begin
         if ((wr && rd) || ((wr || rd) && !cs)) proto_err++;
         if ((l3_wr && l3_rd) || ((l3_wr || l3_rd) && !l3_cs)) proto_err++;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [41:0] vec;
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         vec = {cmd_ready, rsp_valid, rsp_rdata, busy, address, data_in, cs, wr, rd,
                l3_cmd_ready, l3_rsp_valid, l3_busy, l3_cs, l3_wr, l3_rd};
         total++;
         if (vec !== '0) begin
            bad++;
            $display("FAIL reset_outputs cycle %0d: got %h required 0", i, vec);
         end
      end
      rst = 1'b0;
      #1;
      total++;
      if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
         bad++;
         $display("FAIL reset_release: cmd_ready=%b busy=%b required cmd_ready=1 busy=0", cmd_ready, busy);
      end
   endtask

   task automatic test_back_to_back();
      logic exp_cs;
      for (int j = 0; j < 8; j++) begin
         if (j < 4) begin
            cmd_valid = 1'b1;
            cmd_we    = 1'b1;
            cmd_addr  = 8'(j);
            cmd_wdata = 8'hA0 + 8'(j);
         end else begin
            cmd_valid = 1'b0;
         end
         tick();
         exp_cs = (j >= 1) && (j <= 4);
         total++;
         if ({cs, wr, rd, rsp_valid} !== {exp_cs, exp_cs, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL b2b_ctrl cycle %0d: cs/wr/rd/rsp_valid=%b%b%b%b required %b%b00",
                     j, cs, wr, rd, rsp_valid, exp_cs, exp_cs);
         end
         if (exp_cs) begin
            total++;
            if (address !== 8'(j - 1) || data_in !== 8'hA0 + 8'(j - 1)) begin
               bad++;
               $display("FAIL b2b_bus cycle %0d: addr=%h data=%h required addr=%h data=%h",
                        j, address, data_in, 8'(j - 1), 8'hA0 + 8'(j - 1));
            end
         end
      end
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL b2b_idle: busy=%b required 0", busy);
      end
   endtask

   task automatic test_read_back();
      int t_rd = -1;
      int t_rv = -1;
      logic [7:0] got = 8'h00;
      rsp_ready = 1'b1;
      cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 8'h02;
      tick();
      cmd_valid = 1'b0;
      for (int c = 1; c <= 20; c++) begin
         tick();
         if (rd && t_rd < 0) t_rd = c;
         if (rsp_valid && t_rv < 0) begin
            t_rv = c;
            got  = rsp_rdata;
         end
      end
      total++;
      if (t_rd < 0 || t_rv < 0 || (t_rv - t_rd) != 2) begin
         bad++;
         $display("FAIL rd_latency_l1: rd at %0d rsp_valid at %0d, required gap 2", t_rd, t_rv);
      end
      total++;
      if (got !== 8'hA2) begin
         bad++;
         $display("FAIL rd_data_l1: got %h required a2", got);
      end
   endtask

   task automatic test_read_back_l3();
      int t_rd = -1;
      int t_rv = -1;
      logic [7:0] got = 8'h00;
      l3_rsp_ready = 1'b1;
      l3_cmd_valid = 1'b1; l3_cmd_we = 1'b1; l3_cmd_addr = 8'h02; l3_cmd_wdata = 8'h5C;
      tick();
      l3_cmd_we = 1'b0;
      tick();
      l3_cmd_valid = 1'b0;
      for (int c = 1; c <= 30; c++) begin
         tick();
         if (l3_rd && t_rd < 0) t_rd = c;
         if (l3_rsp_valid && t_rv < 0) begin
            t_rv = c;
            got  = l3_rsp_rdata;
         end
      end
      total++;
      if (t_rd < 0 || t_rv < 0 || (t_rv - t_rd) != 4) begin
         bad++;
         $display("FAIL rd_latency_l3: rd at %0d rsp_valid at %0d, required gap 4", t_rd, t_rv);
      end
      total++;
      if (got !== 8'h5C) begin
         bad++;
         $display("FAIL rd_data_l3: got %h required 5c", got);
      end
   endtask

   task automatic test_backpressure();
      int n;
      rsp_ready = 1'b0;
      cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 8'h00;
      tick();
      cmd_addr = 8'h01;
      tick();
      cmd_valid = 1'b0;
      n = 0;
      while (!rsp_valid && n < 20) begin tick(); n++; end
      for (int i = 0; i < 5; i++) begin
         total++;
         if ({rsp_valid, rsp_rdata, cs} !== {1'b1, 8'hA0, 1'b0}) begin
            bad++;
            $display("FAIL bp_hold cycle %0d: valid=%b data=%h cs=%b required 1/a0/0",
                     i, rsp_valid, rsp_rdata, cs);
         end
         tick();
      end
      rsp_ready = 1'b1;
      tick();
      total++;
      if ({rsp_valid, cs} !== 2'b00) begin
         bad++;
         $display("FAIL bp_release: valid=%b cs=%b required 0/0", rsp_valid, cs);
      end
      n = 0;
      while (!rsp_valid && n < 20) begin tick(); n++; end
      total++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 8'hA1) begin
         bad++;
         $display("FAIL bp_second: valid=%b data=%h required 1/a1", rsp_valid, rsp_rdata);
      end
      tick();
   endtask

   task automatic test_fifo_full();
      logic [16:0] cmds [5];
      logic [7:0]  exp_rsp [4];
      logic [7:0]  got [$];
      int acc = 0;
      int n = 0;
      cmds    = '{{1'b1, 8'h01, 8'h5A}, {1'b0, 8'h01, 8'h00}, {1'b0, 8'h00, 8'h00},
                  {1'b0, 8'h03, 8'h00}, {1'b0, 8'h02, 8'h00}};
      exp_rsp = '{8'hA3, 8'h5A, 8'hA0, 8'hA3};
      rsp_ready = 1'b0;
      cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 8'h03;
      tick();
      cmd_valid = 1'b0;
      while (!rsp_valid && n < 20) begin tick(); n++; end
      for (int i = 0; i < 5; i++) begin
         cmd_valid = 1'b1;
         {cmd_we, cmd_addr, cmd_wdata} = cmds[i];
         if (cmd_ready) acc++;
         tick();
      end
      cmd_valid = 1'b0;
      total++;
      if (acc != 4) begin
         bad++;
         $display("FAIL full_accept: accepted %0d required 4", acc);
      end
      total++;
      if ({cmd_ready, busy, rsp_valid} !== 3'b011) begin
         bad++;
         $display("FAIL full_ready: cmd_ready=%b busy=%b valid=%b required 0/1/1", cmd_ready, busy, rsp_valid);
      end
      rsp_ready = 1'b1;
      for (int c = 0; c < 60; c++) begin
         if (rsp_valid) got.push_back(rsp_rdata);
         tick();
      end
      total++;
      if (got.size() != 4) begin
         bad++;
         $display("FAIL full_rsp_count: got %0d responses required 4", got.size());
      end
      for (int i = 0; i < 4; i++) begin
         total++;
         if (i >= got.size()) begin
            bad++;
            $display("FAIL full_order[%0d]: missing response required %h", i, exp_rsp[i]);
         end else if (got[i] !== exp_rsp[i]) begin
            bad++;
            $display("FAIL full_order[%0d]: got %h required %h", i, got[i], exp_rsp[i]);
         end
      end
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL full_drain: busy=%b required 0", busy);
      end
   endtask

   task automatic test_mid_reset();
      int viol = 0;
      int n = 0;
      rsp_ready = 1'b1;
      cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 8'h01;
      tick();
      cmd_we = 1'b1; cmd_addr = 8'h00; cmd_wdata = 8'h77;
      tick();
      cmd_we = 1'b0; cmd_addr = 8'h00;
      tick();
      cmd_valid = 1'b0;
      total++;
      if ({busy, cs, rsp_valid} !== 3'b100) begin
         bad++;
         $display("FAIL mid_pre: busy=%b cs=%b valid=%b required 1/0/0", busy, cs, rsp_valid);
      end
      rst = 1'b1;
      #1;
      total++;
      if ({cs, rd, wr, rsp_valid, busy, cmd_ready, address, data_in, rsp_rdata} !== '0) begin
         bad++;
         $display("FAIL mid_async: cs=%b rd=%b valid=%b busy=%b ready=%b addr=%h din=%h rdata=%h required all 0",
                  cs, rd, rsp_valid, busy, cmd_ready, address, data_in, rsp_rdata);
      end
      tick();
      rst = 1'b0;
      #1;
      total++;
      if ({busy, cmd_ready} !== 2'b01) begin
         bad++;
         $display("FAIL mid_release: busy=%b cmd_ready=%b required 0/1", busy, cmd_ready);
      end
      for (int c = 0; c < 20; c++) begin
         tick();
         if (rsp_valid || cs) viol++;
      end
      total++;
      if (viol != 0) begin
         bad++;
         $display("FAIL mid_no_rsp: %0d cycles with activity, required 0", viol);
      end
      cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 8'h00;
      tick();
      cmd_valid = 1'b0;
      while (!rsp_valid && n < 20) begin tick(); n++; end
      total++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 8'hA0) begin
         bad++;
         $display("FAIL mid_discarded_write: valid=%b data=%h required 1/a0", rsp_valid, rsp_rdata);
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_read_back();
      test_read_back_l3();
      test_backpressure();
      test_fifo_full();
      test_mid_reset();
      total++;
      if (proto_err != 0) begin
         bad++;
         $display("FAIL bus_protocol: %0d illegal wr/rd/cs cycles, required 0", proto_err);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
